// File: rtl/flash_bridge_pkg.sv
// Shared types and default geometry for the flash mirror bridge.
package flash_bridge_pkg;

  localparam int DEF_DATA_W = 256;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_BUS_W  = 32;
  localparam int DEF_QDEPTH = 4;
  localparam int BEATS      = DEF_DATA_W / DEF_BUS_W;
  localparam int BEAT_W     = $clog2(BEATS);

  typedef enum logic [1:0] {
    BOOT,
    READY,
    WB
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/flash_wq.sv
// Write-back FIFO; a push into a full queue is accepted when a pop happens in the same cycle.
module flash_wq
  import flash_bridge_pkg::*;
#(
  parameter type entry_t = wq_entry_t,
  parameter int  QDEPTH  = DEF_QDEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  entry_t                  din_i,
  output entry_t                  dout_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(QDEPTH):0] count_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [QDEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/flash_bridge.sv
// Mirrors the external flash on chip: boot-time load, zero-latency reads, queued write-back.
//   BOOT  | reading every flash beat into the mirror
//   READY | mirror valid, bus idle
//   WB    | writing the queue head back to flash, one beat per ack
module flash_bridge
  import flash_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BUS_W  = DEF_BUS_W,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flash_write,
  input  logic [ADDR_W-1:0]                       add_flash,
  input  logic [DATA_W-1:0]                       write_data,
  output logic [DATA_W-1:0]                       data_flash,
  output logic                                    boot_ready,
  output logic                                    wq_full,
  output logic                                    busy,
  output logic                                    overflow,
  output logic                                    fl_req,
  output logic                                    fl_we,
  output logic [ADDR_W+$clog2(DATA_W/BUS_W)-1:0]  fl_addr,
  output logic [BUS_W-1:0]                        fl_wdata,
  input  logic [BUS_W-1:0]                        fl_rdata,
  input  logic                                    fl_ack
);

  localparam int NBEATS  = DATA_W / BUS_W;
  localparam int NBEAT_W = $clog2(NBEATS);
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int FA_W    = ADDR_W + NBEAT_W;
  localparam int CNT_W   = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e              state_q, state_d;
  logic [FA_W-1:0]     boot_pos_q, boot_pos_d;
  logic [NBEAT_W-1:0]  beat_q, beat_d;
  logic                boot_ready_q, boot_ready_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   mirror_q [DEPTH];

  entry_t              push_entry, head;
  logic                push, pop, q_full, q_empty;
  logic [CNT_W-1:0]    q_count;
  logic                req_c, we_c, boot_wr;
  logic [FA_W-1:0]     addr_c;
  logic [BUS_W-1:0]    wdata_c;

  assign push       = flash_write && boot_ready_q;
  assign push_entry = '{addr: add_flash, data: write_data};

  flash_wq #(
    .entry_t (entry_t),
    .QDEPTH  (QDEPTH)
  ) u_wq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  always_comb begin
    state_d      = state_q;
    boot_pos_d   = boot_pos_q;
    beat_d       = beat_q;
    boot_ready_d = boot_ready_q;
    req_c        = 1'b0;
    we_c         = 1'b0;
    addr_c       = '0;
    wdata_c      = '0;
    pop          = 1'b0;
    boot_wr      = 1'b0;
    case (state_q)
      BOOT: begin
        req_c  = 1'b1;
        addr_c = boot_pos_q;
        if (fl_ack) begin
          boot_wr    = 1'b1;
          boot_pos_d = boot_pos_q + 1'b1;
          if (boot_pos_q == FA_W'(DEPTH * NBEATS - 1)) begin
            state_d      = READY;
            boot_ready_d = 1'b1;
          end
        end
      end
      READY: begin
        if (!q_empty) state_d = WB;
      end
      WB: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = {head.addr, beat_q};
        wdata_c = head.data[beat_q*BUS_W +: BUS_W];
        if (fl_ack) begin
          if (beat_q == NBEAT_W'(NBEATS - 1)) begin
            pop     = 1'b1;
            beat_d  = '0;
            // Still non-empty after this pop if something else is queued or arriving now.
            state_d = (q_count > CNT_W'(1) || push) ? WB : READY;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (flash_write && !boot_ready_q)   overflow_d = 1'b1;
    if (push && q_full && !pop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      boot_pos_q   <= '0;
      beat_q       <= '0;
      boot_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_pos_q   <= boot_pos_d;
      beat_q       <= beat_d;
      boot_ready_q <= boot_ready_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mirror_q[i] <= '0;
    end else if (boot_wr) begin
      mirror_q[boot_pos_q[FA_W-1:NBEAT_W]][boot_pos_q[NBEAT_W-1:0]*BUS_W +: BUS_W] <= fl_rdata;
    end else if (push) begin
      mirror_q[add_flash] <= write_data;
    end
  end

  // Reset parks the FSM in BOOT, which requests; the request must stay low while reset is held.
  assign fl_req     = req_c & rst;
  assign fl_we      = we_c;
  assign fl_addr    = addr_c;
  assign fl_wdata   = wdata_c;
  assign data_flash = mirror_q[add_flash];
  assign boot_ready = boot_ready_q;
  assign overflow   = overflow_q;
  assign wq_full    = q_full;
  assign busy       = !boot_ready_q || !q_empty || (state_q == WB);

endmodule

// File: tb/tb_flash_bridge.sv
// Bench for flash_bridge: flash model answers boot reads with {entry,beat}; write-back beats scoreboarded.
module tb_flash_bridge;
  import flash_bridge_pkg::*;

  localparam int FA_W = DEF_ADDR_W + BEAT_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flash_write;
  logic [DEF_ADDR_W-1:0]   add_flash;
  logic [DEF_DATA_W-1:0]   write_data;
  logic [DEF_DATA_W-1:0]   data_flash;
  logic                    boot_ready, wq_full, busy, overflow;
  logic                    fl_req, fl_we, fl_ack;
  logic [FA_W-1:0]         fl_addr;
  logic [DEF_BUS_W-1:0]    fl_wdata, fl_rdata;

  typedef struct {
    logic [FA_W-1:0]      addr;
    logic [DEF_BUS_W-1:0] data;
  } beat_t;

  beat_t sb_q [$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    boot_cnt = 0;

  flash_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .flash_write (flash_write),
    .add_flash   (add_flash),
    .write_data  (write_data),
    .data_flash  (data_flash),
    .boot_ready  (boot_ready),
    .wq_full     (wq_full),
    .busy        (busy),
    .overflow    (overflow),
    .fl_req      (fl_req),
    .fl_we       (fl_we),
    .fl_addr     (fl_addr),
    .fl_wdata    (fl_wdata),
    .fl_rdata    (fl_rdata),
    .fl_ack      (fl_ack)
  );

  always #5 clk = ~clk;

  assign fl_rdata = DEF_BUS_W'(fl_addr);

  task automatic check(input string tag, input logic [DEF_DATA_W-1:0] got,
                       input logic [DEF_DATA_W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DEF_DATA_W-1:0] boot_word(input int e);
    logic [DEF_DATA_W-1:0] v = '0;
    for (int k = 0; k < BEATS; k++) v[k*DEF_BUS_W +: DEF_BUS_W] = DEF_BUS_W'(e * BEATS + k);
    return v;
  endfunction

  function automatic logic [DEF_DATA_W-1:0] mk(input int base);
    logic [DEF_DATA_W-1:0] v = '0;
    for (int k = 0; k < BEATS; k++) v[k*DEF_BUS_W +: DEF_BUS_W] = DEF_BUS_W'(base + k);
    return v;
  endfunction

  task automatic exp_push(input int a, input logic [DEF_DATA_W-1:0] d);
    beat_t b;
    for (int k = 0; k < BEATS; k++) begin
      b.addr = FA_W'(a * BEATS + k);
      b.data = d[k*DEF_BUS_W +: DEF_BUS_W];
      sb_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      tick();
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_sb_left"}, sb_q.size(), 0);
  endtask

  task automatic wait_beat(input string tag, input int b);
    for (int i = 0; i < 60; i++) begin
      if (fl_req && fl_we && fl_addr[BEAT_W-1:0] == BEAT_W'(b)) break;
      tick();
    end
    check({tag, "_beat_seen"}, fl_addr[BEAT_W-1:0], b);
  endtask

  task automatic write_one(input int a, input logic [DEF_DATA_W-1:0] d, input bit queued);
    flash_write = 1'b1;
    add_flash   = DEF_ADDR_W'(a);
    write_data  = d;
    if (queued) exp_push(a, d);
    tick();
    flash_write = 1'b0;
  endtask

  task automatic boot_seq(input string tag);
    repeat (127) tick();
    check({tag, "_not_yet"}, boot_ready, 0);
    tick();
    check({tag, "_ready"}, boot_ready, 1);
    check({tag, "_beats"}, boot_cnt, BEATS * (2 ** DEF_ADDR_W));
    check({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (fl_req && fl_ack) begin
      if (!fl_we) begin
        check("boot_addr", fl_addr, boot_cnt);
        boot_cnt++;
      end else if (sb_q.size() == 0) begin
        check("wb_extra_beat_q", sb_q.size(), 1);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check("wb_addr", fl_addr, e.addr);
        check("wb_data", fl_wdata, e.data);
      end
    end
  end

  initial begin
    rst         = 1'b0;
    fl_ack      = 1'b1;
    flash_write = 1'b0;
    add_flash   = '0;
    write_data  = '0;
    #2;
    check("rst_req", fl_req, 0);
    check("rst_ready", boot_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_ovf", overflow, 0);
    check("rst_full", wq_full, 0);
    check("rst_data", data_flash, 0);
    tick();
    tick();
    rst = 1'b1;

    // boot
    boot_seq("boot");
    add_flash = 5; #1;
    check("boot_e5", data_flash, boot_word(5));
    add_flash = 15; #1;
    check("boot_e15", data_flash, boot_word(15));

    // single write-back
    add_flash = 3; #1;
    check("wr_old", data_flash, boot_word(3));
    write_one(3, mk(1), 1);
    check("wr_new", data_flash, mk(1));
    wait_idle("wb1", 40);

    // ack stall mid-burst
    write_one(9, mk(32'h900), 1);
    wait_beat("stall", 3);
    fl_ack = 1'b0;
    repeat (3) begin
      tick();
      check("stall_addr", fl_addr, 9 * BEATS + 3);
      check("stall_data", fl_wdata, 32'h903);
    end
    fl_ack = 1'b1;
    wait_idle("stall", 40);

    // overflow with ack held low
    fl_ack = 1'b0;
    write_one(1, mk(32'h1100), 1);
    write_one(2, mk(32'h2200), 1);
    write_one(1, mk(32'h3300), 1);
    check("ovf_not_full", wq_full, 0);
    write_one(4, mk(32'h4400), 1);
    check("ovf_full", wq_full, 1);
    check("ovf_clear", overflow, 0);
    write_one(6, mk(32'h5500), 0);
    check("ovf_set", overflow, 1);
    add_flash = 6; #1;
    check("ovf_mirror5", data_flash, mk(32'h5500));
    add_flash = 1; #1;
    check("ovf_mirror1", data_flash, mk(32'h3300));
    fl_ack = 1'b1;
    wait_idle("ovf", 100);
    check("ovf_sticky", overflow, 1);

    // reset mid-burst
    write_one(7, mk(32'h7700), 1);
    wait_beat("rstwb", 4);
    #1;
    rst = 1'b0;
    sb_q.delete();
    boot_cnt = 0;
    #1;
    check("rstwb_req", fl_req, 0);
    check("rstwb_ready", boot_ready, 0);
    check("rstwb_ovf", overflow, 0);
    check("rstwb_data", data_flash, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    boot_seq("reboot");
    add_flash = 7; #1;
    check("reboot_e7", data_flash, boot_word(7));

    // full queue with a pop on the same edge as a write
    fl_ack = 1'b0;
    for (int a = 10; a < 14; a++) write_one(a, mk(a * 256), 1);
    check("fp_full", wq_full, 1);
    fl_ack = 1'b1;
    wait_beat("fp", 7);
    check("fp_full_pre", wq_full, 1);
    write_one(14, mk(32'he00), 1);
    check("fp_ovf", overflow, 0);
    check("fp_full_post", wq_full, 1);
    wait_idle("fp", 80);
    add_flash = 14; #1;
    check("fp_mirror", data_flash, mk(32'he00));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
